// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/condition inputs to the sequencer
// and every datapath control strobe it produces. The Stop pause request exists
// only when CU_STOP_EN is defined.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON_FF;
`ifdef CU_STOP_EN
  logic        Stop;
`endif
  logic [4:0]  opcode;
  logic        Run;
  logic Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout;

  // Sequencer side: consumes IR/CON_FF (and Stop), drives all strobes.
  modport master (
    input  IR, CON_FF,
`ifdef CU_STOP_EN
    input  Stop,
`endif
    output opcode, Run,
    output Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    output HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin,
    output HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout
  );

  // Datapath side: supplies IR/CON_FF (and Stop), obeys the strobes.
  modport slave (
    output IR, CON_FF,
`ifdef CU_STOP_EN
    output Stop,
`endif
    input  opcode, Run,
    input  Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Cout,
    input  HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Outportin, CONin,
    input  HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired control sequencer: RESET, fetch T0-T2, execute T3-T7, HALT.
// Strobes are a Moore decode of the state register and IR[31:27].
// Optional feature macro: CU_STOP_EN (adds Stop input and a WAIT pause state).
module control_unit #(
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
  input  logic           Clock,
  input  logic           clear,
  control_unit_if.master cu
);

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10011;
  localparam logic [OPW-1:0] OP_IN   = 5'b10101;
  localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
  localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
  localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
`ifdef CU_STOP_EN
    , S_WAIT = 4'd10
`endif
  } state_e;

  state_e         state_q, state_d, done_s;
  logic [OPW-1:0] op_s;
  logic [2:0]     last_s;

  // Final T-step of each instruction class; 2 means no execute phase.
  function automatic logic [2:0] last_step(input logic [OPW-1:0] op);
    logic [2:0] s;
    case (op) inside
      OP_LD, OP_ST:                           s = 3'd7;
      OP_LDI:                                 s = 3'd5;
      [OP_ADD:OP_ORI]:                        s = 3'd5;
      OP_MUL, OP_DIV, OP_BR:                  s = 3'd6;
      OP_NEG, OP_NOT:                         s = 3'd4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: s = 3'd3;
      default:                                s = 3'd2;
    endcase
    return s;
  endfunction

  assign op_s   = cu.IR[31 -: OPW];
  assign last_s = last_step(op_s);

  // State register; clear abandons any in-flight instruction immediately.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // Next-state: step through fetch, run execute up to the class's last step.
  always_comb begin
`ifdef CU_STOP_EN
    done_s = cu.Stop ? S_WAIT : S_T0;
`else
    done_s = S_T0;
`endif
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = (op_s == OP_HALT) ? S_HALT :
                         (last_s <= 3'd2)  ? done_s : S_T3;
      S_T3:    state_d = (last_s <= 3'd3) ? done_s : S_T4;
      S_T4:    state_d = (last_s <= 3'd4) ? done_s : S_T5;
      S_T5:    state_d = (last_s <= 3'd5) ? done_s : S_T6;
      S_T6:    state_d = (last_s <= 3'd6) ? done_s : S_T7;
      S_T7:    state_d = done_s;
      S_HALT:  state_d = S_HALT;
`ifdef CU_STOP_EN
      S_WAIT:  state_d = cu.Stop ? S_WAIT : S_T0;
`endif
      default: state_d = S_RESET;
    endcase
  end

  // Strobe decode from state and opcode; everything idles low by default.
  always_comb begin
    cu.opcode = ADD_OP;
    cu.Run    = (state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7});
    cu.Read = 1'b0; cu.Write = 1'b0; cu.IncPC = 1'b0; cu.Gra = 1'b0; cu.Grb = 1'b0;
    cu.Grc = 1'b0; cu.Rin = 1'b0; cu.Rout = 1'b0; cu.BAout = 1'b0; cu.Cout = 1'b0;
    cu.HIin = 1'b0; cu.LOin = 1'b0; cu.Yin = 1'b0; cu.Zin = 1'b0; cu.PCin = 1'b0;
    cu.IRin = 1'b0; cu.MARin = 1'b0; cu.MDRin = 1'b0; cu.Outportin = 1'b0;
    cu.CONin = 1'b0; cu.HIout = 1'b0; cu.LOout = 1'b0; cu.Zhighout = 1'b0;
    cu.Zlowout = 1'b0; cu.PCout = 1'b0; cu.MDRout = 1'b0; cu.Inportout = 1'b0;
    case (state_q)
      S_T0: begin cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; cu.Zin = 1'b1; end
      S_T1: begin cu.Zlowout = 1'b1; cu.PCin = 1'b1; cu.Read = 1'b1; cu.MDRin = 1'b1; end
      S_T2: begin cu.MDRout = 1'b1; cu.IRin = 1'b1; end
      S_T3: begin
        case (op_s) inside
          [OP_ADD:OP_ORI]:      begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          OP_MUL, OP_DIV:       begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
          OP_NEG, OP_NOT:       begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1;
                                      cu.opcode = op_s; end
          OP_LD, OP_LDI, OP_ST: begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
          OP_BR:   begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
          OP_JR:   begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
          OP_IN:   begin cu.Inportout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_OUT:  begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Outportin = 1'b1; end
          OP_MFHI: begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_MFLO: begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op_s) inside
          [OP_ADD:5'b01010]:    begin cu.Grc = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1;
                                      cu.opcode = op_s; end
          [OP_ADDI:OP_ORI]:     begin cu.Cout = 1'b1; cu.Zin = 1'b1; cu.opcode = op_s; end
          OP_MUL, OP_DIV:       begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1;
                                      cu.opcode = op_s; end
          OP_NEG, OP_NOT:       begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_LD, OP_LDI, OP_ST: begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
          OP_BR:                begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op_s) inside
          [OP_ADD:OP_ORI], OP_LDI: begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_MUL, OP_DIV:          begin cu.Zlowout = 1'b1; cu.LOin = 1'b1; end
          OP_LD, OP_ST:            begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
          OP_BR:                   begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op_s)
          OP_MUL, OP_DIV: begin cu.Zhighout = 1'b1; cu.HIin = 1'b1; end
          OP_LD:          begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
          OP_ST:          begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
          // Only strobe that follows CON_FF: conditional PC load.
          OP_BR:          begin cu.Zlowout = 1'b1; cu.PCin = cu.CON_FF; end
          default: ;
        endcase
      end
      S_T7: begin
        case (op_s)
          OP_LD:   begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
          OP_ST:   cu.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instructions from the test list,
// randomized instruction stream, halt, mid-instruction clear, optional Stop/WAIT.
module tb_control_unit;

  logic Clock = 1'b0;
  logic clear;
  int   n_vec = 0;
  int   n_err = 0;

  control_unit_if cu_if ();
  control_unit dut (.Clock(Clock), .clear(clear), .cu(cu_if));

  always #5 Clock = ~Clock;

  localparam logic [4:0] ADD = 5'b00011;
  localparam logic [26:0] M_READ = 27'd1 << 0,  M_WRITE = 27'd1 << 1,  M_INCPC = 27'd1 << 2;
  localparam logic [26:0] M_GRA  = 27'd1 << 3,  M_GRB   = 27'd1 << 4,  M_GRC   = 27'd1 << 5;
  localparam logic [26:0] M_RIN  = 27'd1 << 6,  M_ROUT  = 27'd1 << 7,  M_BAOUT = 27'd1 << 8;
  localparam logic [26:0] M_COUT = 27'd1 << 9,  M_HIIN  = 27'd1 << 10, M_LOIN  = 27'd1 << 11;
  localparam logic [26:0] M_YIN  = 27'd1 << 12, M_ZIN   = 27'd1 << 13, M_PCIN  = 27'd1 << 14;
  localparam logic [26:0] M_IRIN = 27'd1 << 15, M_MARIN = 27'd1 << 16, M_MDRIN = 27'd1 << 17;
  localparam logic [26:0] M_OUTP = 27'd1 << 18, M_CONIN = 27'd1 << 19, M_HIOUT = 27'd1 << 20;
  localparam logic [26:0] M_LOOUT = 27'd1 << 21, M_ZHI  = 27'd1 << 22, M_ZLO   = 27'd1 << 23;
  localparam logic [26:0] M_PCOUT = 27'd1 << 24, M_MDROUT = 27'd1 << 25, M_INP = 27'd1 << 26;
  localparam logic [26:0] M_DRV = M_ROUT | M_BAOUT | M_COUT | M_HIOUT | M_LOOUT | M_ZHI |
                                  M_ZLO | M_PCOUT | M_MDROUT | M_INP;

  logic [26:0] exp_m[$];
  logic [4:0]  exp_o[$];

  // Strobes gathered into one word, bit order as the M_* masks.
  function automatic logic [26:0] obs_mask();
    return {cu_if.Inportout, cu_if.MDRout, cu_if.PCout, cu_if.Zlowout, cu_if.Zhighout,
            cu_if.LOout, cu_if.HIout, cu_if.CONin, cu_if.Outportin, cu_if.MDRin,
            cu_if.MARin, cu_if.IRin, cu_if.PCin, cu_if.Zin, cu_if.Yin, cu_if.LOin,
            cu_if.HIin, cu_if.Cout, cu_if.BAout, cu_if.Rout, cu_if.Rin, cu_if.Grc,
            cu_if.Grb, cu_if.Gra, cu_if.IncPC, cu_if.Write, cu_if.Read};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of an instruction: strobes, ALU select, Run, and single bus driver.
  task automatic check_step(input string name, input int idx, input logic [26:0] em,
                            input logic [4:0] eo, input logic erun);
    logic [26:0] m;
    m = obs_mask();
    check_val($sformatf("%s T%0d strobes", name, idx), {5'd0, m}, {5'd0, em});
    check_val($sformatf("%s T%0d opcode", name, idx), {27'd0, cu_if.opcode}, {27'd0, eo});
    check_val($sformatf("%s T%0d Run", name, idx), {31'd0, cu_if.Run}, {31'd0, erun});
    check_val($sformatf("%s T%0d one_driver", name, idx),
              {31'd0, ($countones(m & M_DRV) <= 1)}, 32'd1);
  endtask

  function automatic void add(input logic [26:0] m, input logic [4:0] o);
    exp_m.push_back(m);
    exp_o.push_back(o);
  endfunction

  // Reference: register-transfer list for each instruction, fetch included.
  function automatic void build_exp(input logic [4:0] op, input logic cff);
    exp_m.delete();
    exp_o.delete();
    add(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, ADD);
    add(M_ZLO | M_PCIN | M_READ | M_MDRIN, ADD);
    add(M_MDROUT | M_IRIN, ADD);
    if (op >= 5'd3 && op <= 5'd10) begin
      add(M_GRB | M_ROUT | M_YIN, ADD); add(M_GRC | M_ROUT | M_ZIN, op);
      add(M_ZLO | M_GRA | M_RIN, ADD);
    end else if (op >= 5'd11 && op <= 5'd13) begin
      add(M_GRB | M_ROUT | M_YIN, ADD); add(M_COUT | M_ZIN, op);
      add(M_ZLO | M_GRA | M_RIN, ADD);
    end else begin
      case (op)
        5'd14, 5'd15: begin
          add(M_GRA | M_ROUT | M_YIN, ADD); add(M_GRB | M_ROUT | M_ZIN, op);
          add(M_ZLO | M_LOIN, ADD); add(M_ZHI | M_HIIN, ADD);
        end
        5'd16, 5'd17: begin add(M_GRB | M_ROUT | M_ZIN, op); add(M_ZLO | M_GRA | M_RIN, ADD); end
        5'd0: begin
          add(M_GRB | M_BAOUT | M_YIN, ADD); add(M_COUT | M_ZIN, ADD);
          add(M_ZLO | M_MARIN, ADD); add(M_READ | M_MDRIN, ADD); add(M_MDROUT | M_GRA | M_RIN, ADD);
        end
        5'd1: begin
          add(M_GRB | M_BAOUT | M_YIN, ADD); add(M_COUT | M_ZIN, ADD); add(M_ZLO | M_GRA | M_RIN, ADD);
        end
        5'd2: begin
          add(M_GRB | M_BAOUT | M_YIN, ADD); add(M_COUT | M_ZIN, ADD);
          add(M_ZLO | M_MARIN, ADD); add(M_GRA | M_ROUT | M_MDRIN, ADD); add(M_WRITE, ADD);
        end
        5'd18: begin
          add(M_GRA | M_ROUT | M_CONIN, ADD); add(M_PCOUT | M_YIN, ADD);
          add(M_COUT | M_ZIN, ADD); add(M_ZLO | (cff ? M_PCIN : 27'd0), ADD);
        end
        5'd19: add(M_GRA | M_ROUT | M_PCIN, ADD);
        5'd21: add(M_INP | M_GRA | M_RIN, ADD);
        5'd22: add(M_GRA | M_ROUT | M_OUTP, ADD);
        5'd23: add(M_HIOUT | M_GRA | M_RIN, ADD);
        5'd24: add(M_LOOUT | M_GRA | M_RIN, ADD);
        default: ;
      endcase
    end
  endfunction

  // Apply one instruction starting at a T0 negedge; returns at the next T0 (or HALT/WAIT).
  task automatic run_instr(input logic [31:0] ir, input logic cff, input string name);
    cu_if.IR     = ir;
    cu_if.CON_FF = cff;
    build_exp(ir[31:27], cff);
    for (int i = 0; i < exp_m.size(); i++) begin
      check_step(name, i, exp_m[i], exp_o[i], 1'b1);
      @(negedge Clock);
    end
  endtask

  task automatic check_idle(input string name);
    check_step(name, 99, 27'd0, ADD, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    clear        = 1'b0;
    cu_if.IR     = 32'd0;
    cu_if.CON_FF = 1'b0;
`ifdef CU_STOP_EN
    cu_if.Stop   = 1'b0;
`endif
    repeat (2) @(negedge Clock);
    check_idle("reset");
    clear = 1'b1;
    @(negedge Clock);

    run_instr(32'hB0800000, 1'b0, "out");
    run_instr(32'hB0800000, 1'b0, "out2");
    run_instr(32'h18918000, 1'b0, "add");
    run_instr(32'h00800055, 1'b0, "ld");
    run_instr(32'h90800003, 1'b0, "br0");
    run_instr(32'h90800003, 1'b1, "br1");

    for (int k = 0; k < 60; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'b11010) op = 5'b11001;
      run_instr({op, 27'($urandom)}, 1'($urandom), $sformatf("rnd%0d_op%0d", k, op));
    end

    // st interrupted by clear in T6: strobes drop at once, no Write follows.
    cu_if.IR = 32'h10800010;
    build_exp(5'b00010, 1'b0);
    for (int i = 0; i < 7; i++) begin
      check_step("st_abort", i, exp_m[i], exp_o[i], 1'b1);
      if (i < 6) @(negedge Clock);
    end
    #2 clear = 1'b0;
    #1 check_idle("st_clear_now");
    @(negedge Clock);
    check_idle("st_clear_held");
    clear = 1'b1;
    @(negedge Clock);
    run_instr(32'h18918000, 1'b0, "after_abort");

`ifdef CU_STOP_EN
    cu_if.Stop = 1'b1;
    run_instr(32'hB0800000, 1'b0, "out_stop");
    for (int i = 0; i < 4; i++) begin
      check_idle("wait");
      @(negedge Clock);
    end
    cu_if.Stop = 1'b0;
    check_idle("wait_last");
    @(negedge Clock);
    run_instr(32'hB0800000, 1'b0, "out_resume");
`endif

    run_instr(32'hD0000000, 1'b0, "halt");
    for (int i = 0; i < 22; i++) begin
      check_idle("halted");
      @(negedge Clock);
    end
    clear = 1'b0;
    #1 check_idle("halt_clear");
    @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
    run_instr(32'hB0800000, 1'b0, "post_halt");
    run_instr(32'h18918000, 1'b0, "post_halt_add");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
